alu_muldiv_ctrl: RTL and testbench
==================================

# alu_muldiv_ctrl

Execute-stage ALU control with an attached iterative multiply/divide sequencer and HI/LO register pair. Decodes the ALU operation class and function field into the ALU function code, and runs MULT/MULTU/DIV/DIVU as multi-cycle operations. Raises a stall toward the pipeline while the sequencer is busy. Sits in EX beside the single-cycle ALU; HI/LO results feed the EX result mux through `o_hilo_data`.

## Interface

- `NB_ALU_OP`, 3: width of the ALU operation class.
- `NB_FUNC`, 6: width of the function field and of the ALU function code.
- `NB_DATA`, 32: operand and HI/LO width, even, ≥ 4.

- `i_clock`  in  1  single clock, rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  EX holds a valid instruction this cycle.
- `i_alu_op`  in  NB_ALU_OP  operation class from control unit.
- `i_func`  in  NB_FUNC  R-type function field.
- `i_data_a`  in  NB_DATA  rs operand.
- `i_data_b`  in  NB_DATA  rt operand.
- `o_alu_func`  out  NB_FUNC  ALU function code (combinational).
- `o_hilo_data`  out  NB_DATA  HI when func=MFHI, else LO (combinational).
- `o_busy`  out  1  sequencer not IDLE (registered state).
- `o_stall`  out  1  hold IF/ID/EX this cycle (combinational).
- `o_done`  out  1  one-cycle pulse: HI/LO updated by a mul/div.

## Operation

- Decode: ADD→`ADD`, SUB→`SUBU`, FUNC→`i_func`, AND/OR/XOR→same-named code, SHIFTLUI→`SHIFTLUI`, SLTI→`SLT`, any other class→all ones.
- HI/LO function codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. A HI/LO op is class FUNC with one of these codes.
- States: IDLE, MUL, DIV, FIX.
- IDLE with `i_valid`:
  - MULT/MULTU → MUL.
  - DIV/DIVU with `i_data_b`≠0 → DIV.
  - DIV/DIVU with `i_data_b`=0 → stay in IDLE. Write LO=all ones and HI=`i_data_a` at that edge, and pulse `o_done` in the next cycle.
  - MTHI/MTLO → write `i_data_a` to HI/LO at that edge.
- Operand capture at start:
  - Signed ops take magnitudes of both operands and record the result sign (product/quotient sign = XOR of operand signs; remainder sign = dividend sign).
  - Unsigned ops take operands as-is with no negation.
- MUL: shift-add over 2·NB_DATA-bit accumulator, one multiplier bit per cycle, NB_DATA cycles.
- DIV: restoring division, one quotient bit per cycle, NB_DATA cycles.
- The iteration counter is ⌈log2 NB_DATA⌉+1 bits, cleared at start. When it reaches NB_DATA−1 the FSM goes to FIX.
- FIX: apply two's-complement sign fix and write HI/LO. Mul: HI=upper half, LO=lower half. Div: LO=quotient, HI=remainder. Assert `o_done` and return to IDLE.
- Signed corner −2^(NB_DATA−1) ÷ −1: LO=−2^(NB_DATA−1), HI=0 (wraps, no trap).
- `o_busy` = (state≠IDLE).
- `o_stall` = `o_busy` & `i_valid` & (instruction is a HI/LO op). Non-HI/LO instructions proceed while the sequencer runs. A stalled instruction is re-presented unchanged and is accepted in the first IDLE cycle.
- `o_hilo_data` reflects HI/LO register contents. MFHI/MFLO issued in the FIX→IDLE cycle reads the new values, because it is accepted only once IDLE.

## Timing

- Reset (any state, including mid-operation): state=IDLE, counter=0, HI=LO=0, `o_busy`=0, `o_done`=0, `o_stall`=0. The in-flight op is discarded and produces no `o_done`.
- Accept edge T → MUL/DIV through edge T+NB_DATA → FIX during cycle T+NB_DATA+1.
  - HI/LO written at edge T+NB_DATA+1.
  - `o_done` high for the single cycle following that edge.
  - `o_busy` high for cycles T+1..T+NB_DATA+1.
- Divide-by-zero and MTHI/MTLO: single edge, `o_busy` never asserts.
- `i_valid` low in IDLE: no state change.
- `o_alu_func` is purely combinational from `i_alu_op`/`i_func`, independent of state.

## Test plan

- NB_DATA=32, MULTU 0xFFFFFFFF×0xFFFFFFFF → `o_done` 34 cycles after accept; HI=0xFFFFFFFE, LO=0x00000001; `o_busy` high for 33 cycles.
- MULT −3×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV −7÷2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100÷7 → LO=14, HI=2.
- DIV 5÷0 → no busy; next cycle `o_done`=1, LO=0xFFFFFFFF, HI=5. DIV 0x80000000÷0xFFFFFFFF → LO=0x80000000, HI=0.
- MFLO issued on cycle 2 of a MULT → `o_stall`=1 until IDLE, then `o_hilo_data`=new LO. ADD issued mid-op → `o_stall`=0, `o_alu_func`=`ADD`.
- `i_reset` pulsed at iteration 10 of DIVU → next cycle state IDLE, HI=LO=0, no `o_done`. MTHI 0x1234 afterwards → HI=0x1234 in one edge.
- Decode sweep of all `i_alu_op` values → expected codes; the unused class yields 6'b111111.

Source files
------------

// File: rtl/alu_muldiv_ctrl.sv
// Execute-stage ALU function decode plus an iterative multiply/divide sequencer
// owning the HI/LO pair; stalls HI/LO instructions while an operation is in flight.
module alu_muldiv_ctrl #(
    parameter int NB_ALU_OP = 3,
    parameter int NB_FUNC   = 6,
    parameter int NB_DATA   = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [NB_ALU_OP-1:0] i_alu_op,
    input  logic [NB_FUNC-1:0]   i_func,
    input  logic [NB_DATA-1:0]   i_data_a,
    input  logic [NB_DATA-1:0]   i_data_b,
    output logic [NB_FUNC-1:0]   o_alu_func,
    output logic [NB_DATA-1:0]   o_hilo_data,
    output logic                 o_busy,
    output logic                 o_stall,
    output logic                 o_done
);

    localparam int NB_CNT = $clog2(NB_DATA) + 1;

    localparam logic [NB_ALU_OP-1:0] ALU_ADD      = NB_ALU_OP'(0);
    localparam logic [NB_ALU_OP-1:0] ALU_SUB      = NB_ALU_OP'(1);
    localparam logic [NB_ALU_OP-1:0] ALU_FUNC     = NB_ALU_OP'(2);
    localparam logic [NB_ALU_OP-1:0] ALU_AND      = NB_ALU_OP'(3);
    localparam logic [NB_ALU_OP-1:0] ALU_OR       = NB_ALU_OP'(4);
    localparam logic [NB_ALU_OP-1:0] ALU_XOR      = NB_ALU_OP'(5);
    localparam logic [NB_ALU_OP-1:0] ALU_SHIFTLUI = NB_ALU_OP'(6);
    localparam logic [NB_ALU_OP-1:0] ALU_SLTI     = NB_ALU_OP'(7);

    // SHIFTLUI is a private code understood only by our ALU, not a MIPS funct value.
    localparam logic [NB_FUNC-1:0] FN_ADD      = NB_FUNC'(6'b100000);
    localparam logic [NB_FUNC-1:0] FN_SUBU     = NB_FUNC'(6'b100011);
    localparam logic [NB_FUNC-1:0] FN_AND      = NB_FUNC'(6'b100100);
    localparam logic [NB_FUNC-1:0] FN_OR       = NB_FUNC'(6'b100101);
    localparam logic [NB_FUNC-1:0] FN_XOR      = NB_FUNC'(6'b100110);
    localparam logic [NB_FUNC-1:0] FN_SLT      = NB_FUNC'(6'b101010);
    localparam logic [NB_FUNC-1:0] FN_SHIFTLUI = NB_FUNC'(6'b111000);
    localparam logic [NB_FUNC-1:0] FN_MFHI     = NB_FUNC'(6'b010000);
    localparam logic [NB_FUNC-1:0] FN_MTHI     = NB_FUNC'(6'b010001);
    localparam logic [NB_FUNC-1:0] FN_MFLO     = NB_FUNC'(6'b010010);
    localparam logic [NB_FUNC-1:0] FN_MTLO     = NB_FUNC'(6'b010011);
    localparam logic [NB_FUNC-1:0] FN_MULT     = NB_FUNC'(6'b011000);
    localparam logic [NB_FUNC-1:0] FN_MULTU    = NB_FUNC'(6'b011001);
    localparam logic [NB_FUNC-1:0] FN_DIV      = NB_FUNC'(6'b011010);
    localparam logic [NB_FUNC-1:0] FN_DIVU     = NB_FUNC'(6'b011011);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t state, next_state;

    logic [NB_CNT-1:0]    count;
    logic [NB_DATA-1:0]   hi, lo;
    logic [NB_DATA-1:0]   acc_hi, acc_lo, operand;
    logic                 is_mul_op, neg_q, neg_r;

    logic                 is_func, op_mul, op_div, op_mthi, op_mtlo, op_mf;
    logic                 is_hilo, op_signed, b_zero;
    logic                 start_mul, start_div, div_zero, last_iter;
    logic [NB_DATA-1:0]   mag_a, mag_b;
    logic [NB_DATA:0]     mul_sum, div_trial, div_diff;
    logic                 div_ge;
    logic [2*NB_DATA-1:0] product, product_fixed;
    logic [NB_DATA-1:0]   quot_fixed, rem_fixed;

    assign is_func   = (i_alu_op == ALU_FUNC);
    assign op_mul    = is_func && ((i_func == FN_MULT) || (i_func == FN_MULTU));
    assign op_div    = is_func && ((i_func == FN_DIV) || (i_func == FN_DIVU));
    assign op_mthi   = is_func && (i_func == FN_MTHI);
    assign op_mtlo   = is_func && (i_func == FN_MTLO);
    assign op_mf     = is_func && ((i_func == FN_MFHI) || (i_func == FN_MFLO));
    assign is_hilo   = op_mul || op_div || op_mthi || op_mtlo || op_mf;
    assign op_signed = (i_func == FN_MULT) || (i_func == FN_DIV);
    assign b_zero    = (i_data_b == '0);

    assign start_mul = i_valid && op_mul;
    assign start_div = i_valid && op_div && !b_zero;
    assign div_zero  = i_valid && op_div && b_zero;
    assign last_iter = (count == NB_CNT'(NB_DATA - 1));

    // Negating the most negative value leaves the bit pattern unchanged, which is
    // exactly its magnitude when read as unsigned.
    assign mag_a = (op_signed && i_data_a[NB_DATA-1]) ? -i_data_a : i_data_a;
    assign mag_b = (op_signed && i_data_b[NB_DATA-1]) ? -i_data_b : i_data_b;

    always_comb begin
        mul_sum       = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? operand : '0)};
        div_trial     = {acc_hi, acc_lo[NB_DATA-1]};
        div_diff      = div_trial - {1'b0, operand};
        div_ge        = ~div_diff[NB_DATA];
        product       = {acc_hi, acc_lo};
        product_fixed = neg_q ? -product : product;
        quot_fixed    = neg_q ? -acc_lo : acc_lo;
        rem_fixed     = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_mul)      next_state = MUL;
                else if (start_div) next_state = DIV;
            end
            MUL:     if (last_iter) next_state = FIX;
            DIV:     if (last_iter) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state != IDLE);
        o_stall = o_busy && i_valid && is_hilo;
    end

    always_comb begin
        o_alu_func = '1;
        case (i_alu_op)
            ALU_ADD:      o_alu_func = FN_ADD;
            ALU_SUB:      o_alu_func = FN_SUBU;
            ALU_FUNC:     o_alu_func = i_func;
            ALU_AND:      o_alu_func = FN_AND;
            ALU_OR:       o_alu_func = FN_OR;
            ALU_XOR:      o_alu_func = FN_XOR;
            ALU_SHIFTLUI: o_alu_func = FN_SHIFTLUI;
            ALU_SLTI:     o_alu_func = FN_SLT;
            default:      o_alu_func = '1;
        endcase
    end

    assign o_hilo_data = (i_func == FN_MFHI) ? hi : lo;

    // Multiply and divide share acc_hi/acc_lo: product halves, or remainder and
    // the dividend that shifts out as quotient bits shift in.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count     <= '0;
            hi        <= '0;
            lo        <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand   <= '0;
            is_mul_op <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mul || start_div) begin
                        count     <= '0;
                        acc_hi    <= '0;
                        acc_lo    <= mag_a;
                        operand   <= mag_b;
                        is_mul_op <= start_mul;
                        neg_q     <= op_signed && (i_data_a[NB_DATA-1] ^ i_data_b[NB_DATA-1]);
                        neg_r     <= op_signed && i_data_a[NB_DATA-1];
                    end else if (div_zero) begin
                        lo     <= '1;
                        hi     <= i_data_a;
                        o_done <= 1'b1;
                    end else if (i_valid && op_mthi) begin
                        hi <= i_data_a;
                    end else if (i_valid && op_mtlo) begin
                        lo <= i_data_a;
                    end
                end
                MUL: begin
                    acc_hi <= mul_sum[NB_DATA:1];
                    acc_lo <= {mul_sum[0], acc_lo[NB_DATA-1:1]};
                    count  <= count + 1'b1;
                end
                DIV: begin
                    acc_hi <= div_ge ? div_diff[NB_DATA-1:0] : div_trial[NB_DATA-1:0];
                    acc_lo <= {acc_lo[NB_DATA-2:0], div_ge};
                    count  <= count + 1'b1;
                end
                FIX: begin
                    if (is_mul_op) begin
                        hi <= product_fixed[2*NB_DATA-1:NB_DATA];
                        lo <= product_fixed[NB_DATA-1:0];
                    end else begin
                        hi <= rem_fixed;
                        lo <= quot_fixed;
                    end
                    o_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed bench for alu_muldiv_ctrl: hand-computed HI/LO results, latency,
// stall behaviour, reset abort and the ALU function decode.
module tb_alu_muldiv_ctrl;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [2:0]  i_alu_op;
    logic [5:0]  i_func;
    logic [31:0] i_data_a;
    logic [31:0] i_data_b;
    logic [5:0]  o_alu_func;
    logic [31:0] o_hilo_data;
    logic        o_busy;
    logic        o_stall;
    logic        o_done;

    logic [3:0]  wide_alu_op;
    logic [5:0]  wide_alu_func;
    logic [31:0] wide_hilo_data;
    logic        wide_busy, wide_stall, wide_done;

    int assertionCount = 0;
    int failureCount   = 0;
    int lat, busyCnt, n;
    logic sawDone;

    alu_muldiv_ctrl dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .i_alu_op   (i_alu_op),
        .i_func     (i_func),
        .i_data_a   (i_data_a),
        .i_data_b   (i_data_b),
        .o_alu_func (o_alu_func),
        .o_hilo_data(o_hilo_data),
        .o_busy     (o_busy),
        .o_stall    (o_stall),
        .o_done     (o_done)
    );

    // A wider operation-class field leaves classes with no decode.
    alu_muldiv_ctrl #(.NB_ALU_OP(4)) dut_wide (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_valid    (1'b0),
        .i_alu_op   (wide_alu_op),
        .i_func     (6'b100001),
        .i_data_a   (32'h0),
        .i_data_b   (32'h0),
        .o_alu_func (wide_alu_func),
        .o_hilo_data(wide_hilo_data),
        .o_busy     (wide_busy),
        .o_stall    (wide_stall),
        .o_done     (wide_done)
    );

    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [5:0] func,
                                 input logic [31:0] a, input logic [31:0] b);
        i_valid  = valid;
        i_alu_op = op;
        i_func   = func;
        i_data_a = a;
        i_data_b = b;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertionCount++;
        assert (observed === expected)
        else begin
            failureCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkHiLo(input string tag, input logic [31:0] hiExp, input logic [31:0] loExp);
        logic [5:0] saved;
        saved  = i_func;
        i_func = 6'b010000;
        #1;
        checkOutput({tag, "_hi"}, {32'h0, o_hilo_data}, {32'h0, hiExp});
        i_func = 6'b010010;
        #1;
        checkOutput({tag, "_lo"}, {32'h0, o_hilo_data}, {32'h0, loExp});
        i_func = saved;
        #1;
    endtask

    // Latency counts cycles from the accept edge to the cycle showing o_done.
    task automatic runOp(input logic [5:0] func, input logic [31:0] a, input logic [31:0] b,
                         output int latency, output int busyCycles);
        applyStimulus(1'b1, 3'd2, func, a, b);
        tick();
        applyStimulus(1'b0, 3'd2, func, a, b);
        latency    = 1;
        busyCycles = 0;
        while (o_done !== 1'b1 && latency < 60) begin
            if (o_busy) busyCycles++;
            tick();
            latency++;
        end
        checkOutput("done_seen", {63'h0, o_done}, 64'h1);
    endtask

    initial begin
        logic [5:0] decodeExp [8];
        decodeExp = '{6'b100000, 6'b100011, 6'b100001, 6'b100100,
                      6'b100101, 6'b100110, 6'b111000, 6'b101010};
        wide_alu_op = 4'd0;

        i_reset = 1'b1;
        applyStimulus(1'b1, 3'd2, 6'b010010, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("reset_busy", {63'h0, o_busy}, 64'h0);
        checkOutput("reset_done", {63'h0, o_done}, 64'h0);
        checkOutput("reset_stall", {63'h0, o_stall}, 64'h0);
        checkHiLo("reset", 32'h0, 32'h0);
        i_reset = 1'b0;

        applyStimulus(1'b0, 3'd2, 6'b011000, 32'd3, 32'd4);
        tick();
        checkOutput("idle_invalid_busy", {63'h0, o_busy}, 64'h0);

        runOp(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busyCnt);
        checkOutput("multu_latency", 64'(lat), 64'd34);
        checkOutput("multu_busy_cycles", 64'(busyCnt), 64'd33);
        checkOutput("multu_busy_at_done", {63'h0, o_busy}, 64'h0);
        checkHiLo("multu", 32'hFFFFFFFE, 32'h00000001);
        tick();
        checkOutput("multu_done_pulse", {63'h0, o_done}, 64'h0);

        $display("[TB] MULT with MFLO stall and ADD passthrough");
        applyStimulus(1'b1, 3'd2, 6'b011000, 32'hFFFFFFFD, 32'd7);
        tick();
        applyStimulus(1'b0, 3'd2, 6'b011000, 32'hFFFFFFFD, 32'd7);
        tick();
        applyStimulus(1'b1, 3'd2, 6'b010010, 32'h0, 32'h0);
        checkOutput("mflo_stall", {63'h0, o_stall}, 64'h1);
        tick();
        applyStimulus(1'b1, 3'd0, 6'b000000, 32'h0, 32'h0);
        checkOutput("add_no_stall", {63'h0, o_stall}, 64'h0);
        checkOutput("add_func", {58'h0, o_alu_func}, {58'h0, 6'b100000});
        tick();
        applyStimulus(1'b1, 3'd2, 6'b010010, 32'h0, 32'h0);
        n = 0;
        while (o_stall === 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checkOutput("stall_release", {63'h0, o_stall}, 64'h0);
        checkOutput("stall_cycles", 64'(n), 64'd30);
        checkOutput("mult_done_at_release", {63'h0, o_done}, 64'h1);
        checkOutput("mflo_new_lo", {32'h0, o_hilo_data}, {32'h0, 32'hFFFFFFEB});
        applyStimulus(1'b0, 3'd2, 6'b010010, 32'h0, 32'h0);
        checkHiLo("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);

        runOp(6'b011010, 32'hFFFFFFF9, 32'd2, lat, busyCnt);
        checkOutput("div_latency", 64'(lat), 64'd34);
        checkHiLo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);

        runOp(6'b011011, 32'd100, 32'd7, lat, busyCnt);
        checkHiLo("divu", 32'd2, 32'd14);

        runOp(6'b011010, 32'h80000000, 32'hFFFFFFFF, lat, busyCnt);
        checkHiLo("div_wrap", 32'h0, 32'h80000000);

        applyStimulus(1'b1, 3'd2, 6'b011010, 32'd5, 32'd0);
        checkOutput("divzero_busy_before", {63'h0, o_busy}, 64'h0);
        tick();
        applyStimulus(1'b0, 3'd2, 6'b011010, 32'd5, 32'd0);
        checkOutput("divzero_busy_after", {63'h0, o_busy}, 64'h0);
        checkOutput("divzero_done", {63'h0, o_done}, 64'h1);
        checkHiLo("divzero", 32'd5, 32'hFFFFFFFF);
        tick();
        checkOutput("divzero_done_pulse", {63'h0, o_done}, 64'h0);

        $display("[TB] reset during DIVU");
        applyStimulus(1'b1, 3'd2, 6'b011011, 32'd1000, 32'd3);
        tick();
        applyStimulus(1'b0, 3'd2, 6'b011011, 32'd1000, 32'd3);
        repeat (10) tick();
        checkOutput("divu_busy_mid", {63'h0, o_busy}, 64'h1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        checkOutput("abort_busy", {63'h0, o_busy}, 64'h0);
        checkOutput("abort_done", {63'h0, o_done}, 64'h0);
        checkHiLo("abort", 32'h0, 32'h0);
        sawDone = 1'b0;
        repeat (40) begin
            tick();
            if (o_done === 1'b1) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", {63'h0, sawDone}, 64'h0);

        applyStimulus(1'b1, 3'd2, 6'b010001, 32'h1234, 32'h0);
        checkOutput("mthi_no_stall", {63'h0, o_stall}, 64'h0);
        tick();
        applyStimulus(1'b0, 3'd2, 6'b010001, 32'h1234, 32'h0);
        checkOutput("mthi_busy", {63'h0, o_busy}, 64'h0);
        checkHiLo("mthi", 32'h1234, 32'h0);
        applyStimulus(1'b1, 3'd2, 6'b010011, 32'hBEEF, 32'h0);
        tick();
        applyStimulus(1'b0, 3'd2, 6'b010011, 32'hBEEF, 32'h0);
        checkHiLo("mtlo", 32'h1234, 32'hBEEF);

        runOp(6'b011001, 32'd6, 32'd7, lat, busyCnt);
        checkOutput("post_abort_latency", 64'(lat), 64'd34);
        checkHiLo("post_abort_multu", 32'h0, 32'd42);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 3'(i), 6'b100001, 32'h0, 32'h0);
            checkOutput($sformatf("decode_%0d", i), {58'h0, o_alu_func}, {58'h0, decodeExp[i]});
        end
        wide_alu_op = 4'd3;
        #1;
        checkOutput("wide_decode_and", {58'h0, wide_alu_func}, {58'h0, 6'b100100});
        wide_alu_op = 4'd8;
        #1;
        checkOutput("wide_decode_unused8", {58'h0, wide_alu_func}, {58'h0, 6'b111111});
        wide_alu_op = 4'd15;
        #1;
        checkOutput("wide_decode_unused15", {58'h0, wide_alu_func}, {58'h0, 6'b111111});

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failureCount);
        $finish;
    end

endmodule
